// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-limited arbiter merging two writers into one FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic [1:0]            grant,
  output logic [15:0]           cnt0,
  output logic [15:0]           cnt1
);

  localparam logic [0:0] c_idle      = 1'b0;
  localparam logic [0:0] c_serve     = 1'b1;
  localparam logic [7:0] c_last_beat = 8'(BURST_LEN - 1);

  logic [0:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  beat_q,  beat_d;
  logic        ptr_q,   ptr_d;     // 1 = req1 was the last owner released
  logic [15:0] cnt0_q,  cnt0_d;
  logic [15:0] cnt1_q,  cnt1_d;

  logic w_owner_valid;
  logic w_other_valid;
  logic w_release;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= c_idle;
      grant_q <= 2'b00;
      beat_q  <= 8'd0;
      ptr_q   <= 1'b1;
      cnt0_q  <= 16'd0;
      cnt1_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    w_owner_valid = (grant_q[0] & req0_valid) | (grant_q[1] & req1_valid);
    w_other_valid = grant_q[1] ? req0_valid : req1_valid;
    w_release     = (state_q == c_serve) &&
                    ((fifo_wr && (beat_q == c_last_beat)) || !w_owner_valid);

    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    if (fifo_wr && grant_q[0]) cnt0_d = cnt0_q + 16'd1;
    if (fifo_wr && grant_q[1]) cnt1_d = cnt1_q + 16'd1;

    case (state_q)
      c_idle: begin
        if (req0_valid || req1_valid) begin
          state_d = c_serve;
          if (req0_valid && req1_valid) grant_d = ptr_q ? 2'b01 : 2'b10;
          else                          grant_d = req0_valid ? 2'b01 : 2'b10;
        end
      end
      c_serve: begin
        if (w_release) begin
          ptr_d  = grant_q[1];
          beat_d = 8'd0;
          // A waiting peer always wins over a regrant, so handover has no idle gap.
          if (w_other_valid) begin
            grant_d = {grant_q[0], grant_q[1]};
          end else if (!w_owner_valid) begin
            state_d = c_idle;
            grant_d = 2'b00;
          end
        end else if (fifo_wr) begin
          beat_d = beat_q + 8'd1;
        end
      end
      default: begin
        state_d = c_idle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    req0_ready   = reset & grant_q[0] & ~fifo_full;
    req1_ready   = reset & grant_q[1] & ~fifo_full;
    fifo_wr      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    fifo_wr_data = '0;
    if (grant_q[0])      fifo_wr_data = req0_data;
    else if (grant_q[1]) fifo_wr_data = req1_data;
  end

  assign grant = grant_q;
  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, which sets the width of the data words.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, which sets the maximum number of beats per grant (legal range 1..255).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 req0_valid  input  1  requester 0 has a word to write.
REQ-006 req0_data  input  DATA_WIDTH  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle when valid & ready.
REQ-008 req1_valid, req1_data, req1_ready SHALL be identical to REQ-005..007, for requester 1.
REQ-009 fifo_full  input  1  full flag from the downstream FIFO.
REQ-010 fifo_wr  output  1  write strobe to the downstream FIFO.
REQ-011 fifo_wr_data  output  DATA_WIDTH  write data to the downstream FIFO.
REQ-012 grant  output  2  registered one-hot owner; 2'b01 = req0, 2'b10 = req1, 2'b00 = idle.
REQ-013 cnt0, cnt1  output  16  accepted-beat counters, one per requester.

Function
REQ-014 The block SHALL implement a two-state FSM:
- IDLE: grant == 00.
- SERVE: grant is one-hot.
REQ-015 In IDLE, when any valid is high, the block SHALL pick an owner and load grant at the next edge.
- The owner is the valid requester.
- If both requesters are valid, the owner is the requester not last served (round-robin pointer).
- There is one cycle of arbitration latency from valid to grant.
REQ-016 reqN_ready SHALL equal grant[N] & ~fifo_full (combinational).
REQ-017 fifo_wr SHALL equal the owner's valid & ready.
- fifo_wr_data SHALL equal the owner's data, or 0 when grant == 00.
REQ-018 A beat is a cycle with fifo_wr == 1. On each beat:
- the owner's cnt SHALL increment by 1 (wrapping 0xFFFF -> 0x0000);
- the beat counter SHALL increment.
REQ-019 When fifo_full == 1, no beat SHALL occur.
- Grant, beat counter and pointer SHALL hold.
- Full SHALL never cause a release.
REQ-020 Release SHALL occur at the edge ending either:
- the BURST_LEN-th beat of the current grant; or
- any cycle in SERVE where the owner's valid == 0.
REQ-021 On release, the pointer SHALL record the released owner, the beat counter SHALL clear, and the next state SHALL be chosen as follows:
- if the other requester is valid in that cycle, grant SHALL switch directly to it, with no idle cycle;
- otherwise, if the released owner is still valid (burst exhausted), it SHALL be regranted;
- otherwise the FSM SHALL go to IDLE.
REQ-022 Input valid/data not owned SHALL be ignored; at most one fifo_wr per cycle.
REQ-023 With BURST_LEN == 1, grants SHALL alternate every beat when both requesters are valid.

Reset
REQ-024 With reset == 0 at a rising edge, the block SHALL enter the following state at that edge:
- state = IDLE, grant = 00;
- beat counter = 0, cnt0 = cnt1 = 0;
- pointer = "req1 last served", so req0 wins the first tie.
REQ-025 During reset, fifo_wr, req0_ready and req1_ready SHALL be 0.
REQ-026 Reset mid-burst SHALL abort the grant with no further fifo_wr; un-accepted words SHALL be the requester's responsibility.
REQ-027 Reset SHALL take priority over all other inputs.

Verification
REQ-028 Single requester: req0_valid=1 with data 01,02,03,04,05 and fifo_full=0.
- Required: grant=01 one cycle after valid.
- Required: 4 beats (01..04), a release, and a regrant to req0 with no idle cycle.
- Required: 05 written as the 5th beat; cnt0=5.
REQ-029 Tie: both requesters valid continuously from reset, BURST_LEN=4, data req0=A0.., req1=B0...
- Required FIFO order: A0..A3, B0..B3, A4..A7.
- Required: cnt0=8, cnt1=4 after 12 beats.
REQ-030 Backpressure: fifo_full=1 for 3 cycles during the 2nd beat of req0's burst.
- Required: ready=0 and fifo_wr=0 for those cycles, grant held.
- Required: the burst still totals 4 beats; no counter change while full.
REQ-031 Early drop: req1 owner drops valid after 2 beats while req0 is idle.
- Required: release at that edge, grant=00 next cycle, cnt1=2.
- Required: a later req0_valid is granted next cycle.
REQ-032 Reset mid-burst: reset=0 after beat 2 of req0's burst.
- Required: grant=00, cnt0=0, no fifo_wr.
- Required: on a subsequent tie after reset, req0 is granted first.
REQ-033 Counter wrap: preload is not allowed, so drive 65536 beats on req0.
- Required: cnt0 wraps to 0x0000 and cnt1 stays 0.
